// File: rtl/mips_instr_issuer.sv
// Encodes host field sets into MIPS words, buffers them and issues one per GAP+1 cycles with a newinstr strobe.
// Optional ISSUE_COUNT_EN adds a 16-bit count of issued words.
module mips_instr_issuer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int GAP   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [5:0]    in_opcode,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [5:0]    in_funct,
    input  logic [15:0]   in_imm,
    input  logic          run,
    output logic [31:0]   instrword,
    output logic          newinstr,
    output logic [AW:0]   fifo_count,
    output logic          busy,
    output logic          err_illegal
`ifdef ISSUE_COUNT_EN
    ,
    output logic [15:0]   issue_count
`endif
);

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_WAIT  = 1'b1;
    localparam int            GW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [0:0]    r_state;
    logic [GW-1:0] r_gap;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_instrword;
    logic          r_newinstr;
    logic          r_err;

    logic          w_hs;
    logic          w_legal;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_word;

    // in_ready depends only on registered count: a same-edge pop never frees a slot for that push
    assign in_ready = (r_count != FULL);
    assign w_hs     = in_valid && in_ready;
    assign w_legal  = (in_opcode == 6'd0) || (in_opcode == 6'd35) || (in_opcode == 6'd43);
    assign w_push   = w_hs && w_legal;
    assign w_pop    = (r_state == S_IDLE) && run && (r_count != '0);

    always_comb begin
        w_word = {in_opcode, in_rs, in_rt, in_imm};
        if (in_opcode == 6'd0) begin
            w_word = {in_opcode, in_rs, in_rt, in_rd, 5'b00000, in_funct};
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gap       <= '0;
            r_instrword <= '0;
            r_newinstr  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_newinstr <= 1'b0;
            r_err      <= w_hs && !w_legal;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_instrword <= r_mem[r_rd_ptr];
                        r_newinstr  <= 1'b1;
                        r_gap       <= GW'(GAP - 1);
                        r_state     <= S_WAIT;
                    end
                end
                default: begin
                    if (r_gap == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef ISSUE_COUNT_EN
    logic [15:0] r_issue_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_cnt <= '0;
        end else if (w_pop) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign issue_count = r_issue_cnt;
`endif

    assign instrword   = r_instrword;
    assign newinstr    = r_newinstr;
    assign fifo_count  = r_count;
    assign err_illegal = r_err;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: doc/mips_instr_issuer.md
Name: mips_instr_issuer

Overview:
- Instruction-side feeder for the single-cycle MIPS core; it is the encoding end of the core's instrword/newinstr input.
- A host (testbench, loader or debug port) supplies decoded fields, and the block encodes them into 32-bit MIPS words.
- Encoded words are buffered in a FIFO and issued to the core one at a time, each with a one-cycle newinstr strobe, spaced to the core's execution time.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- AW, 3, log2(DEPTH).
- GAP, 4, wait cycles after each issue before the next can be considered; at least 1.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  host field set valid.
- in_ready  out  1  block can accept a field set.
- in_opcode  in  6  opcode field [31:26].
- in_rs  in  5  rs field [25:21].
- in_rt  in  5  rt field [20:16].
- in_rd  in  5  rd field [15:11]; R-type only.
- in_funct  in  6  funct field [5:0]; R-type only.
- in_imm  in  16  immediate field [15:0]; I-type only.
- run  in  1  issue enable.
- instrword  out  32  instruction word to the core.
- newinstr  out  1  one-cycle strobe, high in the first cycle instrword carries a new word.
- fifo_count  out  AW+1  number of words buffered.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- err_illegal  out  1  one-cycle pulse when an unsupported opcode is dropped.

Behaviour:
- Reset values:
  - instrword=0, newinstr=0, err_illegal=0, fifo_count=0, busy=0.
  - FSM in IDLE, gap counter 0, FIFO pointers 0.
- Reset asserted mid-operation:
  - Aborts any WAIT and discards all buffered words.
  - Takes effect at the next edge.
- in_ready = (fifo_count != DEPTH), from registered state only.
  - A pop in the same cycle does not free space for that cycle's push.
- Handshake:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - Fields are sampled at that edge only.
  - in_valid held while in_ready=0 stalls with no data loss.
- Encoding (combinational before push):
  - opcode 0 (R-type): {opcode, rs, rt, rd, 5'b0, funct}; shamt is forced to 0.
  - opcode 35 (lw) and 43 (sw): {opcode, rs, rt, imm}.
  - Any other opcode: the handshake completes, nothing is pushed, and err_illegal=1 in the following cycle.
- FIFO:
  - Circular buffer; read/write pointers are AW bits and wrap from DEPTH-1 to 0.
  - Push and pop on the same edge leave fifo_count unchanged.
  - Push is never accepted when full; pop never occurs when empty.
- FSM states: IDLE, WAIT.
  - IDLE: if run=1 and fifo_count>0 at an edge:
    - head is popped into the instrword register;
    - newinstr=1 for the following cycle;
    - gap counter is loaded with GAP-1;
    - next state WAIT.
    - Otherwise stay in IDLE, newinstr=0.
  - WAIT: newinstr=0.
    - Gap counter 0 at an edge -> IDLE; else decrement.
- Timing:
  - Latency from accepted push into an empty FIFO (IDLE, run=1) to newinstr high: 2 cycles.
  - With run held and the FIFO non-empty, newinstr pulses are exactly GAP+1 cycles apart.
  - run=0 blocks only new issues; a WAIT in progress completes.
- instrword holds the last issued word until the next issue.
  - It never changes while newinstr=0, except on reset.
- busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
- Macro: ISSUE_COUNT_EN.
- Defined:
  - Adds output issue_count, 16 bits.
  - Resets to 0 and increments on every edge where a word is popped for issue.
  - Wraps from 0xFFFF to 0.
  - Illegal (dropped) opcodes are not counted.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then push R-type op=0 rs=1 rt=2 rd=3 funct=0x20 with run=1 -> instrword=0x00221820, newinstr high for exactly 1 cycle, 2 cycles after the push edge.
- Push lw op=35 rs=1 rt=2 imm=4, then sw op=43 rs=1 rt=2 imm=8 back-to-back -> 0x8C220004 then 0xAC220008, newinstr pulses 5 cycles apart (GAP=4), busy low after the final WAIT.
- run=0, push 9 legal words with in_valid held -> fifo_count=8, in_ready=0, 9th stalled. Then run=1 -> all 9 words issued in order, pointers wrap correctly.
- Push op=4 (beq) -> no issue, fifo_count unchanged, err_illegal pulses 1 cycle, in_ready stays 1.
- Assert reset during WAIT with 3 words buffered -> next cycle instrword=0, fifo_count=0, busy=0, no further newinstr.
- With ISSUE_COUNT_EN defined, issue 3 legal words plus 1 illegal -> issue_count=3.
